fft_bitrev_reorder: RTL and testbench



---
 rtl/fft_pkg.sv | 33 +++
 rtl/fft_pingpong_ram.sv | 49 ++++
 rtl/fft_bitrev_reorder.sv | 138 +++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// ============================================================================
// Module  : fft_pkg
// Brief   : Shared constants, sample type and bit-reversal helper for the FFT.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_pkg;

    localparam int FFT_N     = 8;
    localparam int FFT_LOG2N = 3;
    localparam int FFT_W     = 14;

    typedef struct packed {
        logic signed [FFT_W-1:0] re;
        logic signed [FFT_W-1:0] im;
    } cplx_t;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_READ = 1'b1;

    function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] idx);
        logic [FFT_LOG2N-1:0] v_rev;
        v_rev = '0;
        for (int b = 0; b < FFT_LOG2N; b++) begin
            v_rev[b] = idx[FFT_LOG2N-1-b];
        end
        return v_rev;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft_pingpong_ram.sv
// ============================================================================
// Module  : fft_pingpong_ram
// Brief   : Two-bank sample store, one write port and one registered read port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_pingpong_ram
    import fft_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int LOG2N = FFT_LOG2N,
    parameter int DW    = 2 * FFT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic             i_wr_bank,
    input  logic [LOG2N-1:0] i_wr_addr,
    input  logic [DW-1:0]    i_wr_data,
    input  logic             i_rd_en,
    input  logic             i_rd_bank,
    input  logic [LOG2N-1:0] i_rd_addr,
    output logic [DW-1:0]    o_rd_data
);

    logic [DW-1:0] r_mem [0:1][0:N-1];
    logic [DW-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_bank][i_wr_addr] <= i_wr_data;
        end
    end

    // Read register doubles as the output sample register, so it is reset and held when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_bank][i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/fft_bitrev_reorder.sv
// ============================================================================
// Module  : fft_bitrev_reorder
// Brief   : Ping-pong reorder buffer turning bit-reversed FFT output into natural order.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int LOG2N = FFT_LOG2N,
    parameter int W     = FFT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic signed [W-1:0] in_real,
    input  logic signed [W-1:0] in_imag,
    output logic                out_valid,
    output logic signed [W-1:0] out_real,
    output logic signed [W-1:0] out_imag,
    output logic [LOG2N-1:0]    out_index,
    output logic                frame_done
);

    localparam logic [LOG2N-1:0] C_LAST = LOG2N'(N - 1);

    logic             r_wr_sel;
    logic [LOG2N-1:0] r_wr_cnt;
    logic             r_rd_sel;
    logic [LOG2N-1:0] r_rd_cnt;
    logic [1:0]       r_full;
    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;

    logic             w_wr_last;
    logic [1:0]       w_full_set;
    logic [1:0]       w_full_clr;
    logic             w_rd_en;
    logic             w_rd_last;
    logic [LOG2N-1:0] w_rd_addr;
    cplx_t            w_wr_sample;
    cplx_t            w_rd_sample;

    assign w_wr_sample.re = in_real;
    assign w_wr_sample.im = in_imag;
    assign w_wr_last      = in_valid && (r_wr_cnt == C_LAST);
    assign w_full_set     = w_wr_last ? (2'b01 << r_wr_sel) : 2'b00;
    assign w_full_clr     = w_rd_last ? (2'b01 << r_rd_sel) : 2'b00;
    assign w_rd_addr      = bitrev(r_rd_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_sel <= 1'b0;
            r_wr_cnt <= '0;
        end else if (in_valid) begin
            r_wr_cnt <= r_wr_cnt + LOG2N'(1);
            if (w_wr_last) begin
                r_wr_sel <= ~r_wr_sel;
            end
        end
    end

    // Set and clear always address different banks, so both apply in one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 2'b00;
        end else begin
            r_full <= (r_full & ~w_full_clr) | w_full_set;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (r_full[r_rd_sel]) w_state_nxt = ST_READ;
            ST_READ: if (w_rd_last && !r_full[~r_rd_sel]) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rd_en   = (r_state == ST_READ);
        w_rd_last = (r_state == ST_READ) && (r_rd_cnt == C_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_sel   <= 1'b0;
            r_rd_cnt   <= '0;
            out_valid  <= 1'b0;
            out_index  <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= w_rd_en;
            frame_done <= w_rd_last;
            if (w_rd_en) begin
                out_index <= r_rd_cnt;
                r_rd_cnt  <= r_rd_cnt + LOG2N'(1);
                if (w_rd_last) begin
                    r_rd_sel <= ~r_rd_sel;
                end
            end
        end
    end

    fft_pingpong_ram #(
        .N     (N),
        .LOG2N (LOG2N),
        .DW    (2 * W)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_we      (in_valid),
        .i_wr_bank (r_wr_sel),
        .i_wr_addr (r_wr_cnt),
        .i_wr_data (w_wr_sample),
        .i_rd_en   (w_rd_en),
        .i_rd_bank (r_rd_sel),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_sample)
    );

    assign out_real = w_rd_sample.re;
    assign out_imag = w_rd_sample.im;

endmodule

`default_nettype wire

// File: tb/tb_fft_bitrev_reorder.sv
// ============================================================================
// Module  : tb_fft_bitrev_reorder
// Brief   : Scoreboard bench for the bit-reversal reorder buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_bitrev_reorder;
    import fft_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic signed [13:0] in_real = '0;
    logic signed [13:0] in_imag = '0;
    logic               out_valid;
    logic signed [13:0] out_real;
    logic signed [13:0] out_imag;
    logic [2:0]         out_index;
    logic               frame_done;

    fft_bitrev_reorder dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_real    (in_real),
        .in_imag    (in_imag),
        .out_valid  (out_valid),
        .out_real   (out_real),
        .out_imag   (out_imag),
        .out_index  (out_index),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 idx;
        logic signed [13:0] re;
        logic signed [13:0] im;
    } exp_t;

    exp_t               sb_q[$];
    int                 total = 0;
    int                 bad = 0;
    int                 run_len = 0;
    int                 max_run = 0;
    logic signed [13:0] fr_re[8];
    logic signed [13:0] fr_im[8];
    logic signed [13:0] cap_re[8];
    logic signed [13:0] cap_im[8];
    int                 brv[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid) begin
                run_len = run_len + 1;
                if (run_len > max_run) max_run = run_len;
                total = total + 1;
                if (sb_q.size() == 0) begin
                    bad = bad + 1;
                    $display("FAIL unexpected_output idx=%0d re=%0d im=%0d", out_index, out_real, out_imag);
                end else begin
                    e = sb_q.pop_front();
                    if (out_real !== e.re || out_imag !== e.im || out_index !== 3'(e.idx)
                        || frame_done !== (e.idx == 7)) begin
                        bad = bad + 1;
                        $display("FAIL sample got idx=%0d re=%0d im=%0d done=%b want idx=%0d re=%0d im=%0d done=%b",
                                 out_index, out_real, out_imag, frame_done, e.idx, e.re, e.im, (e.idx == 7));
                    end
                    cap_re[out_index] = out_real;
                    cap_im[out_index] = out_imag;
                end
            end else begin
                run_len = 0;
                total = total + 1;
                if (frame_done !== 1'b0) begin
                    bad = bad + 1;
                    $display("FAIL idle_frame_done got=%b want=0", frame_done);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && in_valid && dut.r_wr_cnt == 3'd7 && dut.r_full[dut.r_wr_sel]) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL overflow bank=%0d still full got=1 want=0", dut.r_wr_sel);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_sample(input logic signed [13:0] re, input logic signed [13:0] im);
        in_valid = 1'b1;
        in_real  = re;
        in_imag  = im;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    // mode 0: contiguous, 1: one idle cycle after each sample, 2: random gaps
    task automatic send_frame(input int mode);
        exp_t e;
        for (int p = 0; p < 8; p++) begin
            drive_sample(fr_re[p], fr_im[p]);
            if (p < 7) begin
                if (mode == 1) idle_cycle();
                if (mode == 2) repeat ($urandom_range(1, 0)) idle_cycle();
            end
        end
        for (int k = 0; k < 8; k++) begin
            e.idx = k;
            e.re  = fr_re[brv[k]];
            e.im  = fr_im[brv[k]];
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(posedge clk);
        total = total + 1;
        if (sb_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain_timeout left=%0d want=0", sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_ramp();
        for (int p = 0; p < 8; p++) begin
            fr_re[p] = 14'(p);
            fr_im[p] = -14'(p);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total = total + 5;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        if (out_real !== 14'sd0) begin bad++; $display("FAIL rst_out_real got=%0d want=0", out_real); end
        if (out_imag !== 14'sd0) begin bad++; $display("FAIL rst_out_imag got=%0d want=0", out_imag); end
        if (out_index !== 3'd0) begin bad++; $display("FAIL rst_out_index got=%0d want=0", out_index); end
        if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done got=%b want=0", frame_done); end
        rst = 1'b0;
        idle_cycle();
    endtask

    task automatic test_single();
        load_ramp();
        send_frame(0);
        total = total + 1;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_e0 out_valid got=%b want=0", out_valid); end
        idle_cycle();
        total = total + 1;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_e1 out_valid got=%b want=0", out_valid); end
        idle_cycle();
        total = total + 2;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL latency_e2 out_valid got=%b want=1", out_valid); end
        if (out_index !== 3'd0) begin bad++; $display("FAIL latency_e2 out_index got=%0d want=0", out_index); end
        wait_drain();
        total = total + 1;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL single_end out_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        max_run = 0;
        for (int f = 1; f <= 3; f++) begin
            for (int p = 0; p < 8; p++) begin
                fr_re[p] = 14'(10 * f + p);
                fr_im[p] = 14'(100 * f - p);
            end
            send_frame(0);
        end
        wait_drain();
        total = total + 1;
        if (max_run != 24) begin bad++; $display("FAIL back_to_back_run got=%0d want=24", max_run); end
    endtask

    task automatic test_gapped();
        max_run = 0;
        load_ramp();
        send_frame(1);
        send_frame(1);
        wait_drain();
        total = total + 3;
        if (max_run != 8) begin bad++; $display("FAIL gapped_run got=%0d want=8", max_run); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL gapped_end out_valid got=%b want=0", out_valid); end
        if (dut.r_state !== ST_IDLE) begin bad++; $display("FAIL gapped_state got=%0d want=%0d", dut.r_state, ST_IDLE); end
    endtask

    task automatic test_extremes();
        for (int p = 0; p < 8; p++) begin
            fr_re[p] = 14'(3 * p + 1);
            fr_im[p] = 14'(-5 * p);
        end
        fr_re[1] = -14'sd8192;
        fr_im[1] = -14'sd8192;
        fr_re[6] = 14'sd8191;
        fr_im[6] = 14'sd8191;
        send_frame(0);
        wait_drain();
        total = total + 4;
        if (cap_re[4] !== -14'sd8192) begin bad++; $display("FAIL ext_re4 got=%0d want=-8192", cap_re[4]); end
        if (cap_im[4] !== -14'sd8192) begin bad++; $display("FAIL ext_im4 got=%0d want=-8192", cap_im[4]); end
        if (cap_re[3] !== 14'sd8191) begin bad++; $display("FAIL ext_re3 got=%0d want=8191", cap_re[3]); end
        if (cap_im[3] !== 14'sd8191) begin bad++; $display("FAIL ext_im3 got=%0d want=8191", cap_im[3]); end
    endtask

    task automatic test_reset_mid();
        load_ramp();
        send_frame(0);
        for (int p = 0; p < 5; p++) drive_sample(14'(50 + p), 14'(60 + p));
        total = total + 2;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre out_valid got=%b want=1", out_valid); end
        if (out_index !== 3'd3) begin bad++; $display("FAIL mid_pre out_index got=%0d want=3", out_index); end
        rst = 1'b1;
        #1;
        sb_q.delete();
        run_len = 0;
        total = total + 5;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst out_valid got=%b want=0", out_valid); end
        if (out_real !== 14'sd0) begin bad++; $display("FAIL mid_rst out_real got=%0d want=0", out_real); end
        if (out_imag !== 14'sd0) begin bad++; $display("FAIL mid_rst out_imag got=%0d want=0", out_imag); end
        if (out_index !== 3'd0) begin bad++; $display("FAIL mid_rst out_index got=%0d want=0", out_index); end
        if (frame_done !== 1'b0) begin bad++; $display("FAIL mid_rst frame_done got=%b want=0", frame_done); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            total = total + 1;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL post_rst_stale out_valid got=%b want=0", out_valid); end
        end
        for (int p = 0; p < 8; p++) begin
            fr_re[p] = 14'(p);
            fr_im[p] = 14'(7 - p);
        end
        send_frame(0);
        wait_drain();
    endtask

    task automatic test_random();
        logic [31:0] v_rnd;
        for (int f = 0; f < 100; f++) begin
            for (int p = 0; p < 8; p++) begin
                v_rnd = $urandom;
                fr_re[p] = v_rnd[13:0];
                fr_im[p] = v_rnd[29:16];
            end
            send_frame(2);
        end
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gapped();
        test_extremes();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
